hsid_x_obi_reader: RTL

HSID_X_OBI_READER -- requirements
Module: hsid_x_obi_reader

---
 rtl/hsid_x_obi_reader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hsid_x_obi_reader.sv
// OBI burst reader: fetches a run of 32-bit words and feeds them
// to the datapath through a small credit-limited response FIFO.
package hsid_x_pkg;
  parameter int HSID_WORD_WIDTH       = 32;
  parameter int HSID_HSP_BANDS_WIDTH  = 8;
  parameter int HSID_HSP_LIBRARY_WIDTH = 8;
endpackage

module hsid_x_obi_reader
  import hsid_x_pkg::*;
#(
  parameter int WORD_WIDTH       = HSID_WORD_WIDTH,
  parameter int MEM_ACCESS_WIDTH =
    HSID_HSP_BANDS_WIDTH + HSID_HSP_LIBRARY_WIDTH,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        obi_start,
  input  logic [WORD_WIDTH-1:0]       obi_initial_addr,
  input  logic [MEM_ACCESS_WIDTH-1:0] obi_limit_in,
  input  logic                        cancel,
  output logic                        obi_done,
  output logic                        busy,
  output logic                        obi_req_o,
  input  logic                        obi_gnt_i,
  output logic [WORD_WIDTH-1:0]       obi_addr_o,
  output logic                        obi_we_o,
  output logic [3:0]                  obi_be_o,
  input  logic                        obi_rvalid_i,
  input  logic [WORD_WIDTH-1:0]       obi_rdata_i,
  output logic [WORD_WIDTH-1:0]       data_o,
  output logic                        data_valid_o,
  input  logic                        data_ready_i
);

  localparam int CW = MEM_ACCESS_WIDTH + 1;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int OW = PW + 1;
  localparam logic [OW:0] MAXV = (OW+1)'(MAX_OUTSTANDING);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nx;
  logic [WORD_WIDTH-1:0] r_addr;
  logic [CW-1:0]         r_limit;
  logic [CW-1:0]         r_issued;
  logic [CW-1:0]         r_resp;
  logic [OW-1:0]         r_outst;
  logic [OW-1:0]         r_cnt;
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [WORD_WIDTH-1:0] r_mem [MAX_OUTSTANDING];
  logic                  r_hold;
  logic                  r_done;

  logic [OW:0] w_sum;
  logic        w_req;
  logic        w_gnt;
  logic        w_rv;
  logic        w_flush;
  logic        w_push;
  logic        w_valid;
  logic        w_pop;
  logic        w_start;
  logic        w_zero;
  logic        w_fin;

  assign w_sum   = {1'b0, r_outst} + {1'b0, r_cnt};
  // r_hold keeps an ungranted request alive through cancel
  assign w_req   = r_hold | ((r_state == S_ISSUE) &&
                   (r_issued < r_limit) && (w_sum < MAXV));
  assign w_gnt   = w_req & obi_gnt_i;
  assign w_rv    = obi_rvalid_i && (r_outst != '0);
  assign w_flush = (r_state == S_FLUSH);
  assign w_push  = w_rv && !w_flush;
  assign w_valid = (r_cnt != '0) && !w_flush;
  assign w_pop   = w_valid && data_ready_i;
  assign w_start = (r_state == S_IDLE) && obi_start && !cancel;
  assign w_zero  = (obi_limit_in == '0);
  assign w_fin   = (r_state == S_DRAIN) && !cancel &&
                   (r_resp == r_limit) && (r_cnt == '0);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_start && !w_zero) w_state_nx = S_ISSUE;
      S_ISSUE:
        if (cancel) w_state_nx = S_FLUSH;
        else if (r_issued == r_limit) w_state_nx = S_DRAIN;
      S_DRAIN:
        if (cancel) w_state_nx = S_FLUSH;
        else if (w_fin) w_state_nx = S_IDLE;
      S_FLUSH:
        if ((r_outst == '0) && !r_hold) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_limit  <= '0;
      r_issued <= '0;
      r_resp   <= '0;
      r_outst  <= '0;
      r_hold   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_hold  <= w_req && !obi_gnt_i;
      r_done  <= (w_start && w_zero) || w_fin;
      if (w_start && !w_zero) begin
        r_addr   <= obi_initial_addr;
        r_limit  <= {1'b0, obi_limit_in};
        r_issued <= '0;
        r_resp   <= '0;
      end else begin
        if (w_gnt) begin
          r_addr   <= r_addr + WORD_WIDTH'(4);
          r_issued <= r_issued + 1'b1;
        end
        if (w_push) r_resp <= r_resp + 1'b1;
      end
      if (w_gnt && !w_rv) r_outst <= r_outst + 1'b1;
      else if (!w_gnt && w_rv) r_outst <= r_outst - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= obi_rdata_i;
  end

  assign obi_done     = r_done;
  assign busy         = (r_state != S_IDLE);
  assign obi_req_o    = w_req;
  assign obi_addr_o   = r_addr;
  assign obi_we_o     = 1'b0;
  assign obi_be_o     = 4'hF;
  assign data_valid_o = w_valid;
  assign data_o       = w_valid ? r_mem[r_rp] : '0;

endmodule
